// File: rtl/rcv_pack_if.sv
// Bundle between the receive packer, the size tracker, the SPI byte stage and the RX FIFO.
// The packer connects through the slave modport and its environment through master.
interface rcv_pack_if;
   logic [15:0] rcv_size;
   logic        rcv_last;
   logic        rcv_done;
   logic        rcv_clr;
   logic        byte_vld;
   logic [7:0]  byte_dat;
   logic        fifo_full;
   logic        byte_rdy;
   logic        fifo_wr;
   logic [31:0] fifo_wdat;
   logic        rcv_nxtk;
   logic        rx_ovf;

   modport master (
      output rcv_size, rcv_last, rcv_done, rcv_clr, byte_vld, byte_dat, fifo_full,
      input  byte_rdy, fifo_wr, fifo_wdat, rcv_nxtk, rx_ovf
   );

   modport slave (
      input  rcv_size, rcv_last, rcv_done, rcv_clr, byte_vld, byte_dat, fifo_full,
      output byte_rdy, fifo_wr, fifo_wdat, rcv_nxtk, rx_ovf
   );
endinterface

// File: rtl/rcv_pack.sv
// Receive byte packer: gathers SPI bytes little-endian into 32-bit RX FIFO words,
// with the word boundary taken from the size tracker (full words, or a 1-4 byte tail).
module rcv_pack (
   input  logic      clk,
   input  logic      rst,
   rcv_pack_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FILL, PUSH} state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic        ovf_q, ovf_d;
   logic        byte_rdy, fifo_wr, accept, last_byte;
   logic [15:0] idx_inc;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      word_d   = word_q;
      ovf_d    = ovf_q;
      byte_rdy = 1'b0;
      fifo_wr  = 1'b0;
      accept   = 1'b0;
      idx_inc  = {14'd0, idx_q} + 16'd1;
      // rcv_last implies rcv_size < 5, so a full-width compare equals the 3-bit one
      last_byte = (idx_q == 2'd3) || (bus.rcv_last && (idx_inc == bus.rcv_size));

      case (state_q)
         IDLE: begin
            if (!bus.rcv_done) state_d = FILL;
         end
         FILL: begin
            byte_rdy = !bus.rcv_done;
            accept   = bus.byte_vld && byte_rdy;
            if (bus.rcv_done) begin
               state_d = IDLE;
               idx_d   = 2'd0;
               word_d  = '0;
            end else if (accept) begin
               case (idx_q)
                  2'd0:    word_d[7:0]   = bus.byte_dat;
                  2'd1:    word_d[15:8]  = bus.byte_dat;
                  2'd2:    word_d[23:16] = bus.byte_dat;
                  default: word_d[31:24] = bus.byte_dat;
               endcase
               if (last_byte) begin
                  idx_d   = 2'd0;
                  state_d = PUSH;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         PUSH: begin
            fifo_wr = !bus.fifo_full;
            if (fifo_wr) begin
               word_d  = '0;
               state_d = FILL;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.byte_vld && !byte_rdy) ovf_d = 1'b1;

      // Abort wins over everything in flight, including a pending write and a stray byte
      if (bus.rcv_clr) begin
         state_d  = IDLE;
         idx_d    = 2'd0;
         word_d   = '0;
         ovf_d    = 1'b0;
         byte_rdy = 1'b0;
         fifo_wr  = 1'b0;
      end

      // Reset also masks the combinational strobes so no partial word escapes
      if (rst) begin
         byte_rdy = 1'b0;
         fifo_wr  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         word_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.byte_rdy  = byte_rdy;
   assign bus.fifo_wr   = fifo_wr;
   assign bus.rcv_nxtk  = fifo_wr;
   assign bus.fifo_wdat = word_q;
   assign bus.rx_ovf    = ovf_q;
endmodule

// File: tb/tb_rcv_pack.sv
// Directed bench for rcv_pack with a behavioural size tracker closing the rcv_nxtk loop.
module tb_rcv_pack;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rcv_pack_if bus ();

   rcv_pack u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
      end
   endtask

   // Size tracker: load, decrement by up to 4 per commit, cleared by rcv_clr
   logic [15:0] trk_size = 16'd0;
   logic        ld = 1'b0;
   logic [15:0] ld_val = 16'd0;
   always @(posedge clk) begin
      if (rst || bus.rcv_clr) trk_size <= 16'd0;
      else if (ld)            trk_size <= ld_val;
      else if (bus.rcv_nxtk)  trk_size <= (trk_size > 16'd4) ? trk_size - 16'd4 : 16'd0;
   end
   assign bus.rcv_size = trk_size;
   assign bus.rcv_last = (trk_size < 16'd5);
   assign bus.rcv_done = (trk_size == 16'd0);

   logic [31:0] wr_q[$];
   int          nxtk_cnt = 0;
   always @(negedge clk) begin
      if (bus.fifo_wr)  wr_q.push_back(bus.fifo_wdat);
      if (bus.rcv_nxtk) nxtk_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] v);
      @(posedge clk); #1;
      ld = 1'b1; ld_val = v;
      @(posedge clk); #1;
      ld = 1'b0;
      cyc(3);
   endtask

   // Returns 1 ns into the cycle after the strobe, where a commit would show
   task automatic send(input logic [7:0] d);
      @(posedge clk); #1;
      bus.byte_vld = 1'b1; bus.byte_dat = d;
      @(posedge clk); #1;
      bus.byte_vld = 1'b0;
   endtask

   task automatic clr_pulse();
      @(posedge clk); #1;
      bus.rcv_clr = 1'b1;
      @(posedge clk); #1;
      bus.rcv_clr = 1'b0;
   endtask

   int base;
   int bad;

   initial begin
      bus.rcv_clr = 1'b0; bus.byte_vld = 1'b0; bus.byte_dat = 8'h00; bus.fifo_full = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc(2);
      chk("rst_byte_rdy", {31'd0, bus.byte_rdy}, 0);
      chk("rst_fifo_wr",  {31'd0, bus.fifo_wr}, 0);
      chk("rst_wdat",     bus.fifo_wdat, 32'h0);
      chk("rst_nxtk",     {31'd0, bus.rcv_nxtk}, 0);
      chk("rst_ovf",      {31'd0, bus.rx_ovf}, 0);

      // Two full words
      base = wr_q.size();
      load(16'd8);
      for (int i = 1; i <= 8; i++) begin
         send(i[7:0]);
         if (i == 4 || i == 8) begin
            chk($sformatf("t1_wr_after_b%0d", i), {31'd0, bus.fifo_wr}, 1);
            chk($sformatf("t1_nxtk_after_b%0d", i), {31'd0, bus.rcv_nxtk}, 1);
            chk($sformatf("t1_wdat_after_b%0d", i), bus.fifo_wdat,
                (i == 4) ? 32'h04030201 : 32'h08070605);
         end
         cyc(7);
      end
      chk("t1_nwr",  wr_q.size() - base, 2);
      chk("t1_w0",   wr_q[base], 32'h04030201);
      chk("t1_w1",   wr_q[base+1], 32'h08070605);
      chk("t1_nxtk", nxtk_cnt, 2);
      chk("t1_idle_rdy", {31'd0, bus.byte_rdy}, 0);

      // Full word then a 2-byte tail
      base = wr_q.size();
      load(16'd6);
      for (int i = 0; i < 6; i++) begin
         send(8'h11 + i[7:0]);
         if (i == 3) chk("t2_wdat0", bus.fifo_wdat, 32'h14131211);
         if (i == 5) begin
            chk("t2_tail_wr", {31'd0, bus.fifo_wr}, 1);
            chk("t2_wdat1", bus.fifo_wdat, 32'h00001615);
         end
         cyc(7);
      end
      chk("t2_nwr", wr_q.size() - base, 2);
      chk("t2_size", {16'd0, trk_size}, 0);

      // FIFO backpressure on a single word
      base = wr_q.size();
      load(16'd4);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus.fifo_full = 1'b1;
         send(8'h21 + i[7:0]);
         if (i < 3) cyc(7);
      end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.fifo_wdat !== 32'h24232221 || bus.fifo_wr !== 1'b0 || bus.rcv_nxtk !== 1'b0) bad++;
         if (c < 19) cyc(1);
      end
      chk("t3_stall_stable", bad, 0);
      bus.fifo_full = 1'b0;
      #1;
      chk("t3_release_wr",   {31'd0, bus.fifo_wr}, 1);
      chk("t3_release_nxtk", {31'd0, bus.rcv_nxtk}, 1);
      cyc(4);
      chk("t3_nwr", wr_q.size() - base, 1);
      chk("t3_w0",  wr_q[base], 32'h24232221);

      // Backpressure plus a byte arriving during the stall
      base = wr_q.size();
      load(16'd4);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus.fifo_full = 1'b1;
         send(8'h31 + i[7:0]);
         if (i < 3) cyc(7);
      end
      cyc(3);
      send(8'h99);
      cyc(3);
      chk("t4_ovf_set", {31'd0, bus.rx_ovf}, 1);
      bus.fifo_full = 1'b0;
      cyc(4);
      chk("t4_nwr", wr_q.size() - base, 1);
      chk("t4_w0",  wr_q[base], 32'h34333231);
      chk("t4_ovf_sticky", {31'd0, bus.rx_ovf}, 1);
      clr_pulse();
      chk("t4_ovf_clr", {31'd0, bus.rx_ovf}, 0);

      // Abort mid-word, then a single-byte transfer
      base = wr_q.size();
      load(16'd8);
      send(8'h41); cyc(7);
      send(8'h42); cyc(7);
      clr_pulse();
      cyc(2);
      chk("t5_nwr",  wr_q.size() - base, 0);
      chk("t5_size", {16'd0, trk_size}, 0);
      chk("t5_idle_rdy", {31'd0, bus.byte_rdy}, 0);
      load(16'd1);
      send(8'hAA);
      chk("t5_aa_wr",   {31'd0, bus.fifo_wr}, 1);
      chk("t5_aa_wdat", bus.fifo_wdat, 32'h000000AA);
      cyc(4);
      chk("t5_nwr2", wr_q.size() - base, 1);

      // Reset while a word waits in PUSH and the FIFO frees up the same cycle
      base = wr_q.size();
      load(16'd4);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus.fifo_full = 1'b1;
         send(8'h51 + i[7:0]);
         if (i < 3) cyc(7);
      end
      cyc(2);
      rst = 1'b1; bus.fifo_full = 1'b0;
      #1;
      chk("t6_rst_wr",   {31'd0, bus.fifo_wr}, 0);
      chk("t6_rst_nxtk", {31'd0, bus.rcv_nxtk}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("t6_byte_rdy", {31'd0, bus.byte_rdy}, 0);
      chk("t6_fifo_wr",  {31'd0, bus.fifo_wr}, 0);
      chk("t6_wdat",     bus.fifo_wdat, 32'h0);
      chk("t6_nxtk",     {31'd0, bus.rcv_nxtk}, 0);
      chk("t6_ovf",      {31'd0, bus.rx_ovf}, 0);
      cyc(4);
      chk("t6_nwr", wr_q.size() - base, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
